// File: rtl/rs232_tx_fifo_if.sv
// Purpose: host/serializer bus bundle for the RS-232 transmit FIFO.
// Signals:
//   wr_en, wr_data      host write strobe and data
//   rd_en               read strobe from the serializer
//   rd_data             registered read data
//   full, empty         occupancy flags
//   overflow            sticky dropped-write flag
//   level               word count (only with RS232_TX_FIFO_LEVEL_EN)
// Modports: master (host/serializer side), slave (FIFO side).
interface rs232_tx_fifo_if #(
  parameter int unsigned P_WIDTH = 8,
  parameter int unsigned P_DEPTH = 16
);
  localparam int unsigned CW = $clog2(P_DEPTH) + 1;

  logic               wr_en;
  logic [P_WIDTH-1:0] wr_data;
  logic               full;
  logic               overflow;
  logic               rd_en;
  logic [P_WIDTH-1:0] rd_data;
  logic               empty;
`ifdef RS232_TX_FIFO_LEVEL_EN
  logic [CW-1:0]      level;
`endif

  modport master (
    output wr_en, wr_data, rd_en,
    input  full, overflow, rd_data, empty
`ifdef RS232_TX_FIFO_LEVEL_EN
    , input level
`endif
  );

  modport slave (
    input  wr_en, wr_data, rd_en,
    output full, overflow, rd_data, empty
`ifdef RS232_TX_FIFO_LEVEL_EN
    , output level
`endif
  );
endinterface

// File: rtl/rs232_tx_fifo.sv
// Purpose: transmit FIFO between a host and an RS-232 serializer.
//   Circular buffer with registered read data (no fall-through),
//   registered full/empty derived from the next count, sticky overflow.
// Ports:
//   clk   rising-edge clock
//   rst   synchronous active-high reset
//   bus   rs232_tx_fifo_if.slave (wr_en/wr_data/full/overflow,
//         rd_en/rd_data/empty, level)
// Optional feature: define RS232_TX_FIFO_LEVEL_EN to expose bus.level,
//   the current word count.
module rs232_tx_fifo #(
  parameter int unsigned P_WIDTH = 8,
  parameter int unsigned P_DEPTH = 16
) (
  input  logic              clk,
  input  logic              rst,
  rs232_tx_fifo_if.slave    bus
);
  localparam int unsigned AW = $clog2(P_DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [P_WIDTH-1:0] mem [P_DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [CW-1:0]      count;
  logic [CW-1:0]      count_nxt;
  logic               full_q;
  logic               empty_q;
  logic               overflow_q;
  logic [P_WIDTH-1:0] rd_data_q;
  logic               wr_acc;
  logic               rd_acc;
  logic               wr_drop;

  // Accept/drop decisions and next occupancy.
  // A full FIFO is never empty, so rd_en while full always frees a slot.
  always_comb begin
    rd_acc    = bus.rd_en && !empty_q;
    wr_acc    = bus.wr_en && (!full_q || bus.rd_en);
    wr_drop   = bus.wr_en && full_q && !bus.rd_en;
    count_nxt = count;
    if (wr_acc && !rd_acc) begin
      count_nxt = count + CW'(1);
    end else if (!wr_acc && rd_acc) begin
      count_nxt = count - CW'(1);
    end
  end

  // Pointers, count, flags and read data.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (rd_acc) begin
        rd_ptr    <= rd_ptr + AW'(1);
        rd_data_q <= mem[rd_ptr];
      end
      count   <= count_nxt;
      full_q  <= (count_nxt == CW'(P_DEPTH));
      empty_q <= (count_nxt == '0);
      if (wr_drop) begin
        overflow_q <= 1'b1;
      end
    end
  end

  // Storage array; contents survive reset, only the pointers are cleared.
  always_ff @(posedge clk) begin
    if (!rst && wr_acc) begin
      mem[wr_ptr] <= bus.wr_data;
    end
  end

  assign bus.full     = full_q;
  assign bus.empty    = empty_q;
  assign bus.overflow = overflow_q;
  assign bus.rd_data  = rd_data_q;
`ifdef RS232_TX_FIFO_LEVEL_EN
  assign bus.level    = count;
`endif

endmodule

// File: tb/tb_rs232_tx_fifo.sv
// Purpose: self-checking bench for rs232_tx_fifo (P_WIDTH=8, P_DEPTH=16).
//   Table-driven vectors, directed corner sequences and random traffic,
//   all compared against a queue-based reference model.
module tb_rs232_tx_fifo;
  localparam int unsigned W = 8;
  localparam int unsigned D = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rs232_tx_fifo_if #(.P_WIDTH(W), .P_DEPTH(D)) bus ();
  rs232_tx_fifo #(.P_WIDTH(W), .P_DEPTH(D)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: a queue of words plus the last read value.
  logic [W-1:0] q[$];
  logic [W-1:0] m_rd;
  bit           m_ovf;

  typedef struct {
    bit           r;
    bit           we;
    bit           re;
    logic [W-1:0] wd;
    bit           e_empty;
    bit           e_full;
    bit           e_ovf;
    logic [W-1:0] e_rd;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model(input bit r, input bit we, input logic [W-1:0] wd, input bit re);
    bit was_full;
    bit was_empty;
    if (r) begin
      q.delete();
      m_rd  = '0;
      m_ovf = 1'b0;
    end else begin
      was_full  = (q.size() == D);
      was_empty = (q.size() == 0);
      if (we && was_full && !re) m_ovf = 1'b1;
      if (re && !was_empty) m_rd = q.pop_front();
      if (we && (!was_full || re)) q.push_back(wd);
    end
  endtask

  task automatic compare_model();
    chk("empty", 32'(bus.empty), 32'(q.size() == 0));
    chk("full", 32'(bus.full), 32'(q.size() == D));
    chk("overflow", 32'(bus.overflow), 32'(m_ovf));
    chk("rd_data", 32'(bus.rd_data), 32'(m_rd));
`ifdef RS232_TX_FIFO_LEVEL_EN
    chk("level", 32'(bus.level), 32'(q.size()));
`endif
  endtask

  // Drive one cycle, advance the model at the edge, compare on the falling edge.
  task automatic step(input bit r, input bit we, input logic [W-1:0] wd, input bit re);
    rst         = r;
    bus.wr_en   = we;
    bus.wr_data = wd;
    bus.rd_en   = re;
    @(posedge clk);
    model(r, we, wd, re);
    @(negedge clk);
    compare_model();
  endtask

  vec_t vecs[11];

  initial begin
    logic [W-1:0] first;
    int n_wr;
    int cyc;

    bus.wr_en   = 1'b0;
    bus.wr_data = '0;
    bus.rd_en   = 1'b0;
    q.delete();
    m_rd  = '0;
    m_ovf = 1'b0;

    // Basic write/read, empty-read and simultaneous write+read on empty.
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00};
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 8'h41, 1'b0, 1'b0, 1'b0, 8'h00};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 8'h42, 1'b0, 1'b0, 1'b0, 8'h00};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 8'h43, 1'b0, 1'b0, 1'b0, 8'h00};
    vecs[4]  = '{1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 8'h41};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h41};
    vecs[6]  = '{1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 8'h42};
    vecs[7]  = '{1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 8'h43};
    vecs[8]  = '{1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 8'h43};
    vecs[9]  = '{1'b0, 1'b1, 1'b1, 8'h55, 1'b0, 1'b0, 1'b0, 8'h43};
    vecs[10] = '{1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 8'h55};

    for (int i = 0; i < 11; i++) begin
      step(vecs[i].r, vecs[i].we, vecs[i].wd, vecs[i].re);
      chk($sformatf("vec%0d_empty", i), 32'(bus.empty), 32'(vecs[i].e_empty));
      chk($sformatf("vec%0d_full", i), 32'(bus.full), 32'(vecs[i].e_full));
      chk($sformatf("vec%0d_ovf", i), 32'(bus.overflow), 32'(vecs[i].e_ovf));
      chk($sformatf("vec%0d_rd", i), 32'(bus.rd_data), 32'(vecs[i].e_rd));
    end

    // Fill to full, simultaneous write+read while full, then a dropped write.
    step(1'b1, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, W'(8'h10 + i), 1'b0);
    chk("fill_full", 32'(bus.full), 32'd1);
`ifdef RS232_TX_FIFO_LEVEL_EN
    chk("fill_level", 32'(bus.level), 32'd16);
`endif
    step(1'b0, 1'b1, 8'hAA, 1'b1);
    chk("full_wr_rd_data", 32'(bus.rd_data), 32'h10);
    chk("full_wr_rd_full", 32'(bus.full), 32'd1);
    chk("full_wr_rd_ovf", 32'(bus.overflow), 32'd0);
    step(1'b0, 1'b1, 8'hFF, 1'b0);
    chk("drop_ovf", 32'(bus.overflow), 32'd1);
    chk("drop_full", 32'(bus.full), 32'd1);
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b0, 8'h00, 1'b1);
      chk($sformatf("drain%0d", i), 32'(bus.rd_data), (i < 15) ? 32'(8'h11 + i) : 32'h0AA);
    end
    chk("drain_empty", 32'(bus.empty), 32'd1);
    chk("drain_ovf_sticky", 32'(bus.overflow), 32'd1);

    // Streaming 40 words with one read every third cycle, across pointer wrap.
    step(1'b1, 1'b0, 8'h00, 1'b0);
    n_wr = 0;
    cyc  = 0;
    while ((n_wr < 40 || q.size() != 0) && cyc < 400) begin
      first = (q.size() != 0) ? q[0] : m_rd;
      if (n_wr < 40 && q.size() < D) begin
        step(1'b0, 1'b1, W'(n_wr + 8'h80), (cyc % 3) == 0);
        n_wr++;
      end else begin
        step(1'b0, 1'b0, 8'h00, (cyc % 3) == 0);
      end
      if ((cyc % 3) == 0) chk("wrap_order", 32'(bus.rd_data), 32'(first));
      cyc++;
    end
    chk("wrap_done", 32'(n_wr == 40 && q.size() == 0), 32'd1);
    chk("wrap_last", 32'(bus.rd_data), 32'(8'h80 + 39));

    // Reset with words held discards them.
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, W'(8'h30 + i), 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    step(1'b1, 1'b1, 8'h99, 1'b1);
    chk("rst_empty", 32'(bus.empty), 32'd1);
    chk("rst_ovf", 32'(bus.overflow), 32'd0);
    chk("rst_rd", 32'(bus.rd_data), 32'd0);
    step(1'b0, 1'b1, 8'h77, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    chk("post_rst_rd", 32'(bus.rd_data), 32'h77);
    chk("post_rst_empty", 32'(bus.empty), 32'd1);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 99) < 60),
           W'($urandom), ($urandom_range(0, 99) < 45));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/rs232_tx_fifo.md
RS232_TX_FIFO -- requirements
Module: rs232_tx_fifo

Interface
REQ-001 The block SHALL have parameter P_WIDTH, default 8, meaning the data word width in bits.
REQ-002 The block SHALL have parameter P_DEPTH, default 16, meaning the number of storage entries; it is a power of two and at least 2.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port wr_en, input, 1 bit: host write strobe.
REQ-006 The block SHALL have port wr_data, input, P_WIDTH bits: host write data.
REQ-007 The block SHALL have port full, output, 1 bit: FIFO holds P_DEPTH words.
REQ-008 The block SHALL have port overflow, output, 1 bit: sticky flag, set when a write is dropped.
REQ-009 The block SHALL have port rd_en, input, 1 bit: read strobe from the serializer.
REQ-010 The block SHALL have port rd_data, output, P_WIDTH bits: registered read data.
REQ-011 The block SHALL have port empty, output, 1 bit: FIFO holds zero words.
REQ-012 The block SHALL have port level, output, clogb2(P_DEPTH)+1 bits: word count; this port exists only under RS232_TX_FIFO_LEVEL_EN.

Function
REQ-013 The block SHALL store words in a P_DEPTH-entry circular buffer, addressed by write and read pointers of clogb2(P_DEPTH) bits.
REQ-014 The pointers SHALL wrap from P_DEPTH-1 to 0.
REQ-015 An internal count of clogb2(P_DEPTH)+1 bits SHALL track occupancy in the range 0..P_DEPTH.
REQ-016 A write SHALL be accepted when wr_en=1 and either full=0, or full=1 with rd_en=1 in the same cycle.
REQ-017 An accepted write SHALL store wr_data at the write pointer and then increment the pointer.
REQ-018 A read SHALL be accepted when rd_en=1 and empty=0.
REQ-019 An accepted read SHALL load rd_data from the read pointer on the same clock edge, so data is valid on the cycle after rd_en, and then increment the pointer.
REQ-020 rd_data SHALL hold its last value between reads.
REQ-021 There SHALL be no fall-through: if wr_en=1 and rd_en=1 while empty=1, the write is accepted, the read is ignored, and rd_data is unchanged.
REQ-022 If a read and a write are accepted in the same cycle, the count SHALL be unchanged.
REQ-023 If only a write is accepted, the count SHALL increase by 1; if only a read is accepted, the count SHALL decrease by 1.
REQ-024 full and empty SHALL be registered, derived from the next count, and updated on the same edge as the count, giving zero-cycle flag latency relative to the count.
REQ-025 A write with wr_en=1, full=1 and rd_en=0 SHALL be dropped, with storage unchanged, and SHALL set overflow=1 on the next edge.
REQ-026 A read with rd_en=1 while empty=1 SHALL be ignored, with no pointer movement and no flag change.
REQ-027 The read side SHALL tolerate rd_en pulses of one cycle separated by arbitrary gaps, which is the serializer pattern of one pulse per byte.

Reset
REQ-028 With rst=1 on a clock edge, the block SHALL clear both pointers and the count, set empty=1, full=0, overflow=0, rd_data=0, and level=0 when present.
REQ-029 A reset mid-operation SHALL discard all stored words; storage RAM contents are not cleared.
REQ-030 During reset cycles, wr_en and rd_en SHALL be ignored.
REQ-031 The first write SHALL be accepted on the first edge after rst returns to 0.

Configuration
REQ-032 With macro RS232_TX_FIFO_LEVEL_EN defined, port level SHALL be present and SHALL equal the internal count, updated on the same edge.
REQ-033 With RS232_TX_FIFO_LEVEL_EN undefined, port level SHALL be absent, and full, empty and overflow behaviour SHALL be identical to the defined case.

Verification
REQ-034 Bench SHALL cover: reset, then write 0x41,0x42,0x43 -> empty falls after the first write; three single-cycle rd_en pulses return rd_data 0x41,0x42,0x43, each one cycle after its pulse; empty=1 after the third.
REQ-035 Bench SHALL cover: with P_DEPTH=16, write 16 words -> full=1 and level=16; a 17th write (0xFF) is dropped, overflow=1, and 16 reads return the original words without 0xFF.
REQ-036 Bench SHALL cover: with full=1, wr_en=1 and rd_en=1 together -> the oldest word is read, the new word is accepted, full stays 1, and overflow stays 0.
REQ-037 Bench SHALL cover: with empty=1, wr_en=1 (0x55) and rd_en=1 together -> rd_data unchanged, empty=0, level=1; the next rd_en returns 0x55.
REQ-038 Bench SHALL cover: write 40 words while reading 1 per 3 cycles -> pointers wrap and the data order is preserved across the wrap.
REQ-039 Bench SHALL cover: rst=1 pulse with 5 words held -> empty=1, overflow=0, rd_data=0; a subsequent read returns only data written after reset.
